// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron and its spike consumers.
//   CNT_W_DEF     : default counter width for rate / ISI / window counters
//   BURST_THR_DEF : default window count at or above which a burst is flagged
//   mon_state_t   : spike_rate_monitor FSM states
//   sat_inc       : saturating increment, width-agnostic via a 32-bit carrier
package lif_pkg;

  localparam int unsigned CNT_W_DEF     = 8;
  localparam int unsigned BURST_THR_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_t;

  // Adds inc to value unless value already sits at max_value.
  // Callers zero-extend their counter into 32 bits and truncate the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic        inc,
                                          input logic [31:0] max_value);
    logic [31:0] result;
    result = value;
    if (inc && (value != max_value)) begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for a spike level.
//   clk, rst    : clock, synchronous active-high reset
//   spike       : spike level from the neuron
//   spike_event : high in the cycle where spike rises (spike & ~previous spike)
// The previous-sample register runs every cycle regardless of any consumer
// state, so a spike already high when a consumer starts is not an event.
module spike_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic spike,
  output logic spike_event
);

  logic spike_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike;
    end
  end

  assign spike_event = spike & ~spike_q;

endmodule

// File: rtl/spike_rate_monitor.sv
// Spike rate / inter-spike-interval monitor.
//   clk, rst    : clock, synchronous active-high reset
//   en          : run enable; low returns to IDLE and drops the partial window
//   spike       : spike level; each rising edge is one event
//   window_len  : window length minus one, latched at each window start
//   rate        : event count of the last completed window
//   rate_valid  : one-cycle pulse with each new rate / burst
//   isi         : cycles between the last two events (saturating)
//   isi_valid   : one-cycle pulse with each new isi
//   burst       : rate >= BURST_THR
// All outputs are registers; rate, isi and burst only change on a window
// end, an event, or reset.
module spike_rate_monitor
  import lif_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned BURST_THR = BURST_THR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  input  logic [CNT_W-1:0] window_len,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid,
  output logic             burst
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic spike_event;

  spike_edge_detect u_edge (
    .clk         (clk),
    .rst         (rst),
    .spike       (spike),
    .spike_event (spike_event)
  );

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;        // cycles left in window, 0 = last
  logic [CNT_W-1:0] cnt_q, cnt_d;          // events so far in this window
  logic [CNT_W-1:0] isi_cnt_q, isi_cnt_d;  // cycles since the last event
  logic             have_prev_q, have_prev_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic [CNT_W-1:0] isi_q, isi_d;
  logic             isi_valid_q, isi_valid_d;
  logic             burst_q, burst_d;
  logic [CNT_W-1:0] win_total;             // window count including this cycle

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      cnt_q        <= '0;
      isi_cnt_q    <= '0;
      have_prev_q  <= 1'b0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
      burst_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      cnt_q        <= cnt_d;
      isi_cnt_q    <= isi_cnt_d;
      have_prev_q  <= have_prev_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
      burst_q      <= burst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    cnt_d        = cnt_q;
    isi_cnt_d    = isi_cnt_q;
    have_prev_d  = have_prev_q;
    rate_d       = rate_q;
    isi_d        = isi_q;
    burst_d      = burst_q;
    rate_valid_d = 1'b0;
    isi_valid_d  = 1'b0;
    win_total    = CNT_W'(sat_inc(32'(cnt_q), spike_event, CNT_MAX));

    case (state_q)
      IDLE: begin
        // Events seen while idle are ignored; a fresh window starts next cycle.
        if (en) begin
          state_d     = RUN;
          wcnt_d      = window_len;
          cnt_d       = '0;
          have_prev_d = 1'b0;
          isi_cnt_d   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          // An event on the last cycle belongs to the window that is closing.
          if (wcnt_q == '0) begin
            rate_d       = win_total;
            burst_d      = (32'(win_total) >= BURST_THR);
            rate_valid_d = 1'b1;
            cnt_d        = '0;
            wcnt_d       = window_len;
          end else begin
            cnt_d  = win_total;
            wcnt_d = wcnt_q - CNT_W'(1);
          end

          if (spike_event) begin
            if (have_prev_q) begin
              isi_d       = isi_cnt_q;
              isi_valid_d = 1'b1;
            end
            isi_cnt_d   = CNT_W'(1);
            have_prev_d = 1'b1;
          end else begin
            isi_cnt_d = CNT_W'(sat_inc(32'(isi_cnt_q), 1'b1, CNT_MAX));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign isi        = isi_q;
  assign isi_valid  = isi_valid_q;
  assign burst      = burst_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Self-checking bench for spike_rate_monitor. A timestamp-based reference
// model (window position / event times) predicts every output each cycle.
module tb_spike_rate_monitor;

  localparam int THR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       spike = 1'b0;
  logic [7:0] window_len = 8'd0;
  logic [7:0] rate;
  logic       rate_valid;
  logic [7:0] isi;
  logic       isi_valid;
  logic       burst;

  spike_rate_monitor #(.CNT_W(8), .BURST_THR(THR)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike      (spike),
    .window_len (window_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .isi        (isi),
    .isi_valid  (isi_valid),
    .burst      (burst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         t = 0;
  bit         m_run = 1'b0;
  int         m_pos = 0;
  int         m_len = 1;
  int         m_events = 0;
  int         m_prev_t = -1;
  bit         m_spike_prev = 1'b0;
  logic [7:0] exp_rate = 8'd0;
  logic [7:0] exp_isi = 8'd0;
  logic       exp_rv = 1'b0;
  logic       exp_iv = 1'b0;
  logic       exp_burst = 1'b0;

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    bit ev;
    ev = spike && !m_spike_prev;
    exp_rv = 1'b0;
    exp_iv = 1'b0;
    if (rst) begin
      m_run     = 1'b0;
      exp_rate  = 8'd0;
      exp_isi   = 8'd0;
      exp_burst = 1'b0;
    end else if (!m_run) begin
      if (en) begin
        m_run    = 1'b1;
        m_pos    = 0;
        m_len    = int'(window_len) + 1;
        m_events = 0;
        m_prev_t = -1;
      end
    end else if (!en) begin
      m_run = 1'b0;
    end else begin
      if (ev) m_events++;
      if (m_pos == m_len - 1) begin
        exp_rate  = sat8(m_events);
        exp_burst = (int'(exp_rate) >= THR);
        exp_rv    = 1'b1;
        m_events  = 0;
        m_pos     = 0;
        m_len     = int'(window_len) + 1;
      end else begin
        m_pos++;
      end
      if (ev) begin
        if (m_prev_t >= 0) begin
          exp_isi = sat8(t - m_prev_t);
          exp_iv  = 1'b1;
        end
        m_prev_t = t;
      end
    end
    m_spike_prev = rst ? 1'b0 : spike;
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; spike = 1'b1; window_len = 8'd9;
    step();
    step();
    checks += 5;
    if (rate !== 8'd0)    begin errors++; $display("FAIL reset rate: got %0d want 0", rate); end
    if (rate_valid !== 0) begin errors++; $display("FAIL reset rate_valid: got %0b want 0", rate_valid); end
    if (isi !== 8'd0)     begin errors++; $display("FAIL reset isi: got %0d want 0", isi); end
    if (isi_valid !== 0)  begin errors++; $display("FAIL reset isi_valid: got %0b want 0", isi_valid); end
    if (burst !== 0)      begin errors++; $display("FAIL reset burst: got %0b want 0", burst); end
    spike = 1'b0;
    step();
  endtask

  task automatic test_periodic();
    int n_rv;
    n_rv = 0;
    rst = 1'b0; en = 1'b1; window_len = 8'd99;
    for (int k = 0; k < 302; k++) begin
      spike = (k % 10 == 5);
      step();
      checks += 5;
      if (rate !== exp_rate)        begin errors++; $display("FAIL periodic rate t=%0d got %0d want %0d", t, rate, exp_rate); end
      if (rate_valid !== exp_rv)    begin errors++; $display("FAIL periodic rate_valid t=%0d got %0b want %0b", t, rate_valid, exp_rv); end
      if (isi !== exp_isi)          begin errors++; $display("FAIL periodic isi t=%0d got %0d want %0d", t, isi, exp_isi); end
      if (isi_valid !== exp_iv)     begin errors++; $display("FAIL periodic isi_valid t=%0d got %0b want %0b", t, isi_valid, exp_iv); end
      if (burst !== exp_burst)      begin errors++; $display("FAIL periodic burst t=%0d got %0b want %0b", t, burst, exp_burst); end
      if (rate_valid === 1'b1) begin
        n_rv++;
        $display("periodic window t=%0d rate=%0d burst=%0b", t, rate, burst);
        checks++;
        if (rate !== 8'd10 || burst !== 1'b1) begin errors++; $display("FAIL periodic window rate/burst: got %0d/%0b want 10/1", rate, burst); end
      end
      if (isi_valid === 1'b1) begin
        checks++;
        if (isi !== 8'd10) begin errors++; $display("FAIL periodic isi value: got %0d want 10", isi); end
      end
    end
    checks++;
    if (n_rv != 3) begin errors++; $display("FAIL periodic pulse count: got %0d want 3", n_rv); end
  endtask

  task automatic test_held_sat();
    int n_rv, n_iv;
    logic [7:0] first_rate, isi_seen;
    n_rv = 0; n_iv = 0; first_rate = 8'hxx; isi_seen = 8'hxx;
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; window_len = 8'd99;
    for (int k = 0; k < 326; k++) begin
      spike = ((k >= 1) && (k <= 20)) || (k == 321);
      step();
      checks += 5;
      if (rate !== exp_rate)        begin errors++; $display("FAIL held rate t=%0d got %0d want %0d", t, rate, exp_rate); end
      if (rate_valid !== exp_rv)    begin errors++; $display("FAIL held rate_valid t=%0d got %0b want %0b", t, rate_valid, exp_rv); end
      if (isi !== exp_isi)          begin errors++; $display("FAIL held isi t=%0d got %0d want %0d", t, isi, exp_isi); end
      if (isi_valid !== exp_iv)     begin errors++; $display("FAIL held isi_valid t=%0d got %0b want %0b", t, isi_valid, exp_iv); end
      if (burst !== exp_burst)      begin errors++; $display("FAIL held burst t=%0d got %0b want %0b", t, burst, exp_burst); end
      if (rate_valid === 1'b1) begin
        if (n_rv == 0) first_rate = rate;
        n_rv++;
      end
      if (isi_valid === 1'b1) begin
        n_iv++;
        isi_seen = isi;
      end
    end
    checks += 3;
    if (first_rate !== 8'd1) begin errors++; $display("FAIL held first rate: got %0d want 1", first_rate); end
    if (n_iv != 1)           begin errors++; $display("FAIL held isi pulse count: got %0d want 1", n_iv); end
    if (isi_seen !== 8'd255) begin errors++; $display("FAIL held saturated isi: got %0d want 255", isi_seen); end
  endtask

  task automatic test_boundary();
    logic [7:0] rates[$];
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; window_len = 8'd3;
    for (int k = 0; k < 10; k++) begin
      spike = (k == 4);
      step();
      checks += 2;
      if (rate_valid !== exp_rv) begin errors++; $display("FAIL boundary rate_valid t=%0d got %0b want %0b", t, rate_valid, exp_rv); end
      if (rate !== exp_rate)     begin errors++; $display("FAIL boundary rate t=%0d got %0d want %0d", t, rate, exp_rate); end
      if (rate_valid === 1'b1) rates.push_back(rate);
    end
    checks++;
    if (rates.size() != 2) begin
      errors++; $display("FAIL boundary pulse count: got %0d want 2", rates.size());
    end else begin
      checks += 2;
      if (rates[0] !== 8'd1) begin errors++; $display("FAIL boundary first window: got %0d want 1", rates[0]); end
      if (rates[1] !== 8'd0) begin errors++; $display("FAIL boundary second window: got %0d want 0", rates[1]); end
    end
  endtask

  task automatic test_enable_drop();
    bit seen_first;
    seen_first = 1'b0;
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    step();
    rst = 1'b0; window_len = 8'd99;
    for (int k = 0; k < 280; k++) begin
      en = !((k >= 150) && (k < 170));
      spike = (k % 10 == 5);
      step();
      checks += 5;
      if (rate !== exp_rate)        begin errors++; $display("FAIL endrop rate t=%0d got %0d want %0d", t, rate, exp_rate); end
      if (rate_valid !== exp_rv)    begin errors++; $display("FAIL endrop rate_valid t=%0d got %0b want %0b", t, rate_valid, exp_rv); end
      if (isi !== exp_isi)          begin errors++; $display("FAIL endrop isi t=%0d got %0d want %0d", t, isi, exp_isi); end
      if (isi_valid !== exp_iv)     begin errors++; $display("FAIL endrop isi_valid t=%0d got %0b want %0b", t, isi_valid, exp_iv); end
      if (burst !== exp_burst)      begin errors++; $display("FAIL endrop burst t=%0d got %0b want %0b", t, burst, exp_burst); end
      if ((k >= 150) && (k <= 170)) begin
        checks++;
        if (rate_valid !== 1'b0 || rate !== 8'd10 || isi !== 8'd10 || burst !== 1'b1) begin
          errors++;
          $display("FAIL endrop hold k=%0d got rv=%0b rate=%0d isi=%0d burst=%0b want 0/10/10/1", k, rate_valid, rate, isi, burst);
        end
      end
      if ((k > 170) && spike && !seen_first) begin
        seen_first = 1'b1;
        checks++;
        if (isi_valid !== 1'b0) begin errors++; $display("FAIL endrop first isi after re-enable: got %0b want 0", isi_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; window_len = 8'd4;
    for (int k = 0; k < 31; k++) begin
      rst = (k == 12);
      spike = (k % 4 == 2) || (k == 12);
      step();
      checks += 5;
      if (rate !== exp_rate)        begin errors++; $display("FAIL rstmid rate t=%0d got %0d want %0d", t, rate, exp_rate); end
      if (rate_valid !== exp_rv)    begin errors++; $display("FAIL rstmid rate_valid t=%0d got %0b want %0b", t, rate_valid, exp_rv); end
      if (isi !== exp_isi)          begin errors++; $display("FAIL rstmid isi t=%0d got %0d want %0d", t, isi, exp_isi); end
      if (isi_valid !== exp_iv)     begin errors++; $display("FAIL rstmid isi_valid t=%0d got %0b want %0b", t, isi_valid, exp_iv); end
      if (burst !== exp_burst)      begin errors++; $display("FAIL rstmid burst t=%0d got %0b want %0b", t, burst, exp_burst); end
      if (k == 11) begin
        checks++;
        if (rate !== 8'd2 || isi !== 8'd4) begin errors++; $display("FAIL rstmid pre-reset rate/isi: got %0d/%0d want 2/4", rate, isi); end
      end
      if (k == 12) begin
        checks++;
        if ({rate, rate_valid, isi, isi_valid, burst} !== 19'd0) begin
          errors++;
          $display("FAIL rstmid after reset: got rate=%0d rv=%0b isi=%0d iv=%0b burst=%0b want all 0", rate, rate_valid, isi, isi_valid, burst);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_window_change();
    int times[$];
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; window_len = 8'd9;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) window_len = 8'd4;
      spike = 1'($urandom_range(0, 1));
      step();
      checks += 2;
      if (rate_valid !== exp_rv) begin errors++; $display("FAIL wchange rate_valid t=%0d got %0b want %0b", t, rate_valid, exp_rv); end
      if (rate !== exp_rate)     begin errors++; $display("FAIL wchange rate t=%0d got %0d want %0d", t, rate, exp_rate); end
      if (rate_valid === 1'b1) times.push_back(k);
    end
    checks++;
    if (times.size() != 4) begin
      errors++; $display("FAIL wchange pulse count: got %0d want 4", times.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (times[i] != 10 + 5 * i) begin errors++; $display("FAIL wchange pulse %0d at k=%0d want k=%0d", i, times[i], 10 + 5 * i); end
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; window_len = 8'd15;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0) begin
        window_len = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
      end
      if ($urandom_range(0, 3) == 0) spike = ~spike;
      step();
      checks += 5;
      if (rate !== exp_rate)        begin errors++; $display("FAIL random rate t=%0d got %0d want %0d", t, rate, exp_rate); end
      if (rate_valid !== exp_rv)    begin errors++; $display("FAIL random rate_valid t=%0d got %0b want %0b", t, rate_valid, exp_rv); end
      if (isi !== exp_isi)          begin errors++; $display("FAIL random isi t=%0d got %0d want %0d", t, isi, exp_isi); end
      if (isi_valid !== exp_iv)     begin errors++; $display("FAIL random isi_valid t=%0d got %0b want %0b", t, isi_valid, exp_iv); end
      if (burst !== exp_burst)      begin errors++; $display("FAIL random burst t=%0d got %0b want %0b", t, burst, exp_burst); end
      if (rate_valid === 1'b1) $display("random window t=%0d rate=%0d burst=%0b", t, rate, burst);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_held_sat();
    test_boundary();
    test_enable_drop();
    test_reset_mid();
    test_window_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
